// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the coordinate width used by every renderer.
package vga_timing_pkg;

    localparam int unsigned COORD_W  = 10;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned CLK_DIV_DEF = 4;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator to the renderers and colour mux.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               pixel_tick;
    logic               line_start;
    logic               frame_start;

    modport master (
        output x, y, hsync, vsync, video_on, pixel_tick, line_start, frame_start
    );

    modport slave (
        input  x, y, hsync, vsync, video_on, pixel_tick, line_start, frame_start
    );

endinterface

// File: rtl/pixel_clk_en.sv
// System-clock prescaler: one-clk pixel-rate enable, first pulse on the CLK_DIV-th edge after reset.
module pixel_clk_en #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_pixel_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_clk_en: CLK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_pixel_tick;
    logic             w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);

    // Tick is the registered wrap, so with CLK_DIV = 1 it holds high from the first edge on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_pixel_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
            r_pixel_tick <= w_div_wrap;
        end
    end

    assign o_pixel_tick = r_pixel_tick;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: h/v scan counters, sync/blank decode and line/frame strobes.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
    parameter int unsigned CLK_DIV     = vga_timing_pkg::CLK_DIV_DEF,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master o_vga
);

    import vga_timing_pkg::COORD_W;

    localparam int unsigned LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned COORD_SPAN  = 1 << COORD_W;
    localparam int unsigned HS_BEG      = H_ACTIVE + H_FP;
    localparam int unsigned VS_BEG      = V_ACTIVE + V_FP;

    if (LINE_TOTAL > COORD_SPAN || LINE_TOTAL == 0) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL must be 1..1024");
    end
    if (FRAME_TOTAL > COORD_SPAN || FRAME_TOTAL == 0) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL must be 1..1024");
    end

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(LINE_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(FRAME_TOTAL - 1);

    function automatic logic in_window(
        input logic [COORD_W-1:0] c,
        input int unsigned        lo,
        input int unsigned        len
    );
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

    logic               w_pixel_tick;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;
    logic               w_line_wrap;
    logic               w_frame_wrap;

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_video_on;
    logic               r_line_start;
    logic               r_frame_start;

    pixel_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_en (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_pixel_tick (w_pixel_tick)
    );

    // Next scan position; decoded outputs are registered from it so they line up with x/y.
    always_comb begin
        w_h_nxt      = r_h;
        w_v_nxt      = r_v;
        w_line_wrap  = w_pixel_tick && (r_h == H_LAST);
        w_frame_wrap = w_line_wrap && (r_v == V_LAST);
        if (w_pixel_tick) begin
            if (r_h == H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == V_LAST) ? '0 : r_v + COORD_W'(1);
            end else begin
                w_h_nxt = r_h + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_video_on    <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= in_window(w_h_nxt, HS_BEG, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= in_window(w_v_nxt, VS_BEG, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_video_on    <= (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign o_vga.x           = r_h;
    assign o_vga.y           = r_v;
    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.video_on    = r_video_on;
    assign o_vga.pixel_tick  = w_pixel_tick;
    assign o_vga.line_start  = r_line_start;
    assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size 640x480 instance plus a tiny CLK_DIV=1 active-high-sync raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vga_timing_gen_if vga_big ();
    vga_timing_gen_if vga_small ();

    vga_timing_gen u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .o_vga (vga_big)
    );

    // 15 x 8 raster: active 8x4, hsync x=10..12, vsync y=5..6.
    vga_timing_gen #(
        .H_ACTIVE    (8),
        .H_FP        (2),
        .H_SYNC      (3),
        .H_BP        (2),
        .V_ACTIVE    (4),
        .V_FP        (1),
        .V_SYNC      (2),
        .V_BP        (1),
        .CLK_DIV     (1),
        .SYNC_ACTIVE (1'b1)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .o_vga (vga_small)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_x",        32'(vga_big.x), 0);
        check_eq("rst_y",        32'(vga_big.y), 0);
        check_eq("rst_hsync",    32'(vga_big.hsync), 1);
        check_eq("rst_vsync",    32'(vga_big.vsync), 1);
        check_eq("rst_video_on", 32'(vga_big.video_on), 1);
        check_eq("rst_tick",     32'(vga_big.pixel_tick), 0);
        check_eq("rst_ls",       32'(vga_big.line_start), 0);
        check_eq("rst_fs",       32'(vga_big.frame_start), 0);
        check_eq("rst_s_x",      32'(vga_small.x), 0);
        check_eq("rst_s_y",      32'(vga_small.y), 0);
        check_eq("rst_s_hsync",  32'(vga_small.hsync), 0);
        check_eq("rst_s_vsync",  32'(vga_small.vsync), 0);
        check_eq("rst_s_vid",    32'(vga_small.video_on), 1);
        check_eq("rst_s_tick",   32'(vga_small.pixel_tick), 0);
    endtask

    initial begin
        int unsigned p, bx, by, sx, sy;
        int unsigned hs_low_clks, tick_cnt, fs1, fs2;
        bit          found;

        hs_low_clks = 0;
        tick_cnt    = 0;
        fs1         = 0;
        fs2         = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // k counts active edges after release; outputs sampled on the following falling edge.
        for (int k = 1; k <= 3204; k++) begin
            @(posedge clk);
            @(negedge clk);

            p  = (32'(k) - 1) / 4;
            bx = p % 800;
            by = p / 800;
            check_eq("big_x",     32'(vga_big.x), bx);
            check_eq("big_y",     32'(vga_big.y), by);
            check_eq("big_tick",  32'(vga_big.pixel_tick), 32'((k % 4) == 0));
            check_eq("big_hsync", 32'(vga_big.hsync), 32'(!(bx >= 656 && bx <= 751)));
            check_eq("big_vsync", 32'(vga_big.vsync), 1);
            check_eq("big_vid",   32'(vga_big.video_on), 32'(bx < 640));
            check_eq("big_ls",    32'(vga_big.line_start), 32'(k == 3201));
            check_eq("big_fs",    32'(vga_big.frame_start), 0);
            if (k <= 3200) begin
                if (vga_big.hsync == 1'b0) hs_low_clks++;
                if (vga_big.pixel_tick)    tick_cnt++;
            end

            case (k)
                2624: check_eq("hs_before_656", 32'(vga_big.hsync), 1);
                2625: check_eq("hs_fall_x",     32'(vga_big.x), 656);
                2561: check_eq("vid_drop_x640", 32'(vga_big.video_on), 0);
                3009: check_eq("hs_rise_x752",  32'(vga_big.hsync), 1);
                3201: check_eq("wrap_y1",       32'(vga_big.y), 1);
                default: ;
            endcase

            if (k <= 250) begin
                p  = 32'(k) - 1;
                sx = p % 15;
                sy = (p / 15) % 8;
                check_eq("s_x",     32'(vga_small.x), sx);
                check_eq("s_y",     32'(vga_small.y), sy);
                check_eq("s_tick",  32'(vga_small.pixel_tick), 1);
                check_eq("s_hsync", 32'(vga_small.hsync), 32'(sx >= 10 && sx <= 12));
                check_eq("s_vsync", 32'(vga_small.vsync), 32'(sy >= 5 && sy <= 6));
                check_eq("s_vid",   32'(vga_small.video_on), 32'(sx < 8 && sy < 4));
                check_eq("s_ls",    32'(vga_small.line_start), 32'(p >= 15 && (p % 15) == 0));
                check_eq("s_fs",    32'(vga_small.frame_start), 32'(p >= 120 && (p % 120) == 0));
                if (vga_small.frame_start) begin
                    if (fs1 == 0) fs1 = 32'(k);
                    else if (fs2 == 0) fs2 = 32'(k);
                end
                if (k == 120) begin
                    check_eq("s_last_x", 32'(vga_small.x), 14);
                    check_eq("s_last_y", 32'(vga_small.y), 7);
                end
                if (k == 121) begin
                    check_eq("s_wrap_ls", 32'(vga_small.line_start), 1);
                    check_eq("s_wrap_fs", 32'(vga_small.frame_start), 1);
                end
            end
        end

        check_eq("hsync_low_clks", hs_low_clks, 384);
        check_eq("ticks_per_line", tick_cnt, 800);
        check_eq("s_first_fs",     fs1, 121);
        check_eq("s_frame_period", fs2 - fs1, 120);

        // Async reset mid-line at x = 300, checked before any further clock edge.
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            @(negedge clk);
            if (vga_big.x == 10'd300) found = 1'b1;
        end
        check_eq("reach_x300", 32'(found), 1);
        check_eq("pre_rst_y",  32'(vga_big.y), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
